multicycle_datapath: RTL and testbench
======================================

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high, with ports named clk and reset.
REQ-002 Parameter PC_W SHALL default to 32 and set the program-counter and imem_addr width (16..32).
REQ-003 Parameter RESET_PC SHALL default to 0 and set the PC value loaded on reset.
REQ-004 Parameter DMEM_AW SHALL default to 32 and set the dmem_addr width (byte address, low bits of ALU result).
REQ-005 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- imem_addr  out  PC_W  current PC (byte address)
- imem_data  in  32  instruction at imem_addr (combinational read)
- dmem_addr  out  DMEM_AW  data address
- dmem_wdata  out  32  store data
- dmem_re  out  1  load strobe
- dmem_we  out  1  store strobe
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- dmem_ready  in  1  memory access complete
- dbg_sel  in  2  debug select
- dbg_value  out  32  debug word
- halted  out  1  core stopped
- err  out  1  stopped on illegal opcode
- retired  out  32  instructions retired

Function
REQ-006 The FSM SHALL use states FETCH, DECODE, EXEC, MEM, WB and HALT; each state lasts one cycle except MEM.
REQ-007 In FETCH the block SHALL latch imem_data into IR and latch PC+4 into PC, truncated to PC_W.
REQ-008 In DECODE the block SHALL latch rs/rt register reads into A/B and the sign-extended imm[15:0] into IMM.
REQ-009 The supported ISA SHALL be:
- R-type (op 0x00): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed), 0x00 sll, 0x02 srl; shift amount is shamt applied to rt.
- I-type: addi 0x08, lw 0x23, sw 0x2B, beq 0x04.
- Jump: j 0x02.
- Halt: op 0x3F.
REQ-010 Transitions SHALL be:
- R-type/addi: EXEC->WB->FETCH (4 cycles).
- lw: EXEC->MEM->WB->FETCH (5 cycles + wait).
- sw: EXEC->MEM->FETCH (4 cycles + wait).
- beq/j: EXEC->FETCH (3 cycles).
- halt op or illegal op/funct: DECODE->HALT.
REQ-011 Arithmetic SHALL be 32-bit two's complement with overflow ignored; slt SHALL write 1 or 0.
REQ-012 beq taken (A==B) SHALL set PC = PC+4 + (IMM<<2), truncated to PC_W; not-taken SHALL leave PC unchanged.
REQ-013 j SHALL set PC = {PC[31:28], addr26, 2'b00}, truncated to PC_W (upper field omitted when PC_W<=28).
REQ-014 In MEM, dmem_re or dmem_we SHALL be asserted with dmem_addr and dmem_wdata held stable until the cycle dmem_ready=1; that cycle SHALL latch dmem_rdata for lw and leave MEM on the next edge.
REQ-015 dmem_re and dmem_we SHALL never be asserted outside MEM and SHALL never both be 1.
REQ-016 dmem_ready outside MEM SHALL be ignored; dmem_ready=1 on the first MEM cycle SHALL give zero wait states.
REQ-017 Writeback destination SHALL be rd for R-type and rt for addi/lw; writes to r0 SHALL be discarded, and r0 SHALL always read 0.
REQ-018 retired SHALL increment once on the final cycle of each completed instruction, excluding halt/illegal, and SHALL wrap at 2^32.
REQ-019 In HALT the PC, registers and retired SHALL be frozen, halted=1, and only reset SHALL exit HALT; err=1 SHALL apply only when HALT was entered on an illegal op.
REQ-020 dbg_value SHALL be 0:last ALU result, 1:PC zero-extended, 2:IR, 3:retired (combinational on dbg_sel).

Reset
REQ-021 On reset the block SHALL set PC=RESET_PC, state FETCH, r1..r31=0, IR=0, ALU result=0, retired=0, halted=0, err=0, dmem_re=0, dmem_we=0.
REQ-022 Reset SHALL take priority over all activity; reset during MEM SHALL drop the strobes at the same edge and the pending access SHALL be abandoned.

Verification
REQ-023 Program addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; halt -> r3=2, retired=3, halted=1 after 12 cycles plus the halt decode.
REQ-024 sw r3,8(r0) with dmem_ready held low 3 cycles -> dmem_we=1 for exactly 4 cycles at dmem_addr=8 with dmem_wdata=2; instruction takes 7 cycles.
REQ-025 lw r4,8(r0) with dmem_rdata=0xDEADBEEF and ready on the first cycle -> r4=0xDEADBEEF, 5 cycles, dmem_re high for 1 cycle.
REQ-026 beq r1,r1,-1 at PC 0x10 -> PC returns to 0x10 every 3 cycles, and retired increments each iteration.
REQ-027 add r0,r1,r1 then dbg_sel=0 and read r0 via add r5,r0,r0 -> r5=0; op 0x3E -> halted=1, err=1, retired unchanged.
REQ-028 reset asserted mid-MEM with PC_W=16 and RESET_PC=0x100 -> next cycle imem_addr=0x100, strobes=0, retired=0.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC[/MEM][/WB] per instruction, HALT on halt or illegal opcode.
// Latency: 3 cycles (beq/j), 4 (R-type/addi/sw), 5 (lw); MEM adds one cycle per dmem_ready=0 cycle.
// Backpressure: dmem_ready=0 holds the core in MEM with strobe, address and store data stable.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   imem_addr/imem_data   instruction fetch (PC byte address, combinational read data)
//   dmem_*                data port: addr/wdata/re/we out, rdata/ready in
//   dbg_sel/dbg_value     debug mux: 0 ALU result, 1 PC, 2 IR, 3 retired
//   halted/err/retired    status: stopped, stopped on illegal opcode, retired-instruction count
module multicycle_datapath #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DMEM_AW  = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [31:0]        imem_data,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               dmem_re,
    output logic               dmem_we,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ready,
    input  logic [1:0]         dbg_sel,
    output logic [31:0]        dbg_value,
    output logic               halted,
    output logic               err,
    output logic [31:0]        retired
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [31:0]     imm;
    logic [31:0]     alu_out;
    logic [31:0]     mdr;
    logic [31:0]     regs [0:31];

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_res;
    logic        legal;
    logic [31:0] pc_ext;
    logic [31:0] br_off;
    logic [31:0] j_target;
    logic [4:0]  dest;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];

    // r0 is never written, but force the read to zero anyway so it is hardwired
    assign rs_val = (rs == 5'd0) ? 32'h0 : regs[rs];
    assign rt_val = (rt == 5'd0) ? 32'h0 : regs[rt];

    assign dest     = (op == OP_R) ? rd : rt;
    assign br_off   = imm << 2;
    // upper PC nibble is zero (and truncated away) when PC_W <= 28
    assign j_target = {pc_ext[31:28], ir[25:0], 2'b00};

    always_comb begin
        pc_ext           = 32'h0;
        pc_ext[PC_W-1:0] = pc;
    end

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_R: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = 32'h0;
        if (op == OP_R) begin
            case (funct)
                6'h20:   alu_res = a + b;
                6'h22:   alu_res = a - b;
                6'h24:   alu_res = a & b;
                6'h25:   alu_res = a | b;
                6'h2A:   alu_res = {31'h0, $signed(a) < $signed(b)};
                6'h00:   alu_res = b << shamt;
                6'h02:   alu_res = b >> shamt;
                default: alu_res = 32'h0;
            endcase
        end else begin
            // addi and load/store effective address
            alu_res = a + imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= RESET_PC[PC_W-1:0];
            ir      <= 32'h0;
            a       <= 32'h0;
            b       <= 32'h0;
            imm     <= 32'h0;
            alu_out <= 32'h0;
            mdr     <= 32'h0;
            retired <= 32'h0;
            halted  <= 1'b0;
            err     <= 1'b0;
            dmem_re <= 1'b0;
            dmem_we <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else begin
            case (state)
                FETCH: begin
                    ir    <= imem_data;
                    pc    <= pc + PC_STEP;
                    state <= DECODE;
                end
                DECODE: begin
                    a   <= rs_val;
                    b   <= rt_val;
                    imm <= {{16{ir[15]}}, ir[15:0]};
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else if (!legal) begin
                        halted <= 1'b1;
                        err    <= 1'b1;
                        state  <= HALT;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (op)
                        OP_LW: begin
                            alu_out <= alu_res;
                            dmem_re <= 1'b1;
                            state   <= MEM;
                        end
                        OP_SW: begin
                            alu_out <= alu_res;
                            dmem_we <= 1'b1;
                            state   <= MEM;
                        end
                        OP_BEQ: begin
                            // pc already holds PC+4 from FETCH
                            if (a == b) begin
                                pc <= pc + br_off[PC_W-1:0];
                            end
                            retired <= retired + 32'd1;
                            state   <= FETCH;
                        end
                        OP_J: begin
                            pc      <= j_target[PC_W-1:0];
                            retired <= retired + 32'd1;
                            state   <= FETCH;
                        end
                        default: begin
                            alu_out <= alu_res;
                            state   <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (dmem_ready) begin
                        dmem_re <= 1'b0;
                        dmem_we <= 1'b0;
                        mdr     <= dmem_rdata;
                        if (op == OP_LW) begin
                            state <= WB;
                        end else begin
                            retired <= retired + 32'd1;
                            state   <= FETCH;
                        end
                    end
                end
                WB: begin
                    if (dest != 5'd0) begin
                        regs[dest] <= (op == OP_LW) ? mdr : alu_out;
                    end
                    retired <= retired + 32'd1;
                    state   <= FETCH;
                end
                default: begin
                    // HALT: everything frozen until reset
                    state <= HALT;
                end
            endcase
        end
    end

    assign imem_addr  = pc;
    assign dmem_addr  = alu_out[DMEM_AW-1:0];
    assign dmem_wdata = b;

    always_comb begin
        case (dbg_sel)
            2'd0:    dbg_value = alu_out;
            2'd1:    dbg_value = pc_ext;
            2'd2:    dbg_value = ir;
            default: dbg_value = retired;
        endcase
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath (PC_W=16, RESET_PC=0x100).
// Latency: n/a (testbench).
// Backpressure: a small memory responder delays dmem_ready by wait_cfg cycles.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_re;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [1:0]  dbg_sel = 2'd0;
    logic [31:0] dbg_value;
    logic        halted;
    logic        err;
    logic [31:0] retired;

    logic [31:0] imem [0:255];
    logic [31:0] rd_val = 32'hDEADBEEF;
    int          wait_cfg = 0;
    int          mem_wait = 0;
    int          we_total = 0;
    int          re_total = 0;
    logic        both_seen = 1'b0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ret  = 0;

    multicycle_datapath #(.PC_W(16), .RESET_PC(32'h100), .DMEM_AW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .dbg_sel    (dbg_sel),
        .dbg_value  (dbg_value),
        .halted     (halted),
        .err        (err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    assign imem_data  = imem[imem_addr[9:2]];
    assign dmem_rdata = rd_val;
    assign dmem_ready = (mem_wait >= wait_cfg);

    // memory responder: counts strobe cycles, records the last store
    always @(posedge clk) begin
        if (dmem_re || dmem_we) mem_wait <= mem_wait + 1;
        else                    mem_wait <= 0;
        if (dmem_we) begin
            we_total <= we_total + 1;
            wr_addr  <= dmem_addr;
            wr_data  <= dmem_wdata;
        end
        if (dmem_re) re_total <= re_total + 1;
        if (dmem_re && dmem_we) both_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    localparam logic [31:0] HALT_I = 32'hFC000000;

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = HALT_I;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_ret = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // runs one instruction to retirement, checks its cycle count and results
    task automatic run_instr(input string tag, input int cyc, input logic [31:0] alu, input logic [15:0] pc);
        logic [31:0] start;
        int n;
        start = retired;
        n = 0;
        while (retired == start && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        exp_ret++;
        chk({tag, ".cycles"}, n, cyc);
        chk({tag, ".retired"}, retired, exp_ret);
        chk({tag, ".pc"}, {16'h0, imem_addr}, {16'h0, pc});
        dbg_sel = 2'd0;
        #1 chk({tag, ".alu"}, dbg_value, alu);
        dbg_sel = 2'd3;
        #1 chk({tag, ".dbg_ret"}, dbg_value, exp_ret);
        dbg_sel = 2'd0;
    endtask

    task automatic wait_halt(input string tag, input int cyc);
        int n;
        n = 0;
        while (!halted && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".halt_cycles"}, n, cyc);
    endtask

    initial begin
        int we0, re0, n;

        // halt program: reset state, three ALU ops then halt
        clear_imem();
        imem[64] = i_ins(8, 0, 1, 5);
        imem[65] = i_ins(8, 0, 2, -3);
        imem[66] = r_ins(1, 2, 3, 0, 32'h20);
        do_reset();
        chk("rst.pc", {16'h0, imem_addr}, 32'h100);
        chk("rst.halted", halted, 0);
        chk("rst.err", err, 0);
        chk("rst.retired", retired, 0);
        chk("rst.strobes", {dmem_re, dmem_we}, 0);
        dbg_sel = 2'd2;
        #1 chk("rst.ir", dbg_value, 0);
        dbg_sel = 2'd1;
        #1 chk("rst.dbg_pc", dbg_value, 32'h100);
        dbg_sel = 2'd0;
        #1 chk("rst.alu", dbg_value, 0);
        run_instr("p1.addi1", 4, 32'h5, 16'h104);
        run_instr("p1.addi2", 4, 32'hFFFFFFFD, 16'h108);
        run_instr("p1.add", 4, 32'h2, 16'h10C);
        wait_halt("p1", 2);
        chk("p1.err", err, 0);
        tick(5);
        chk("p1.frozen_pc", {16'h0, imem_addr}, 32'h110);
        chk("p1.frozen_ret", retired, 3);
        chk("p1.halted_stays", halted, 1);

        // full program: memory ops, ALU mix, r0, branch and jump
        clear_imem();
        imem[64] = i_ins(8, 0, 1, 5);
        imem[65] = i_ins(8, 0, 2, -3);
        imem[66] = r_ins(1, 2, 3, 0, 32'h20);
        imem[67] = i_ins(32'h2B, 0, 3, 8);
        imem[68] = i_ins(32'h23, 0, 4, 8);
        imem[69] = i_ins(32'h2B, 0, 4, 12);
        imem[70] = r_ins(1, 2, 6, 0, 32'h22);
        imem[71] = r_ins(1, 2, 7, 0, 32'h24);
        imem[72] = r_ins(1, 2, 8, 0, 32'h25);
        imem[73] = r_ins(2, 1, 9, 0, 32'h2A);
        imem[74] = r_ins(1, 2, 10, 0, 32'h2A);
        imem[75] = r_ins(0, 1, 11, 4, 32'h00);
        imem[76] = r_ins(0, 2, 12, 28, 32'h02);
        imem[77] = r_ins(1, 1, 0, 0, 32'h20);
        imem[78] = r_ins(0, 0, 5, 0, 32'h20);
        imem[79] = i_ins(32'h2B, 0, 5, 4);
        imem[80] = i_ins(4, 1, 2, 5);
        imem[81] = {6'h02, 26'h4};
        imem[4]  = i_ins(4, 1, 1, -1);
        wait_cfg = 0;
        do_reset();
        run_instr("p2.addi1", 4, 32'h5, 16'h104);
        run_instr("p2.addi2", 4, 32'hFFFFFFFD, 16'h108);
        run_instr("p2.add", 4, 32'h2, 16'h10C);
        dbg_sel = 2'd2;
        #1 chk("p2.ir", dbg_value, 32'h00221820);
        dbg_sel = 2'd0;
        wait_cfg = 3;
        we0 = we_total;
        re0 = re_total;
        run_instr("p2.sw_wait", 7, 32'h8, 16'h110);
        chk("p2.sw_we_cycles", we_total - we0, 4);
        chk("p2.sw_re_cycles", re_total - re0, 0);
        chk("p2.sw_addr", wr_addr, 32'h8);
        chk("p2.sw_data", wr_data, 32'h2);
        wait_cfg = 0;
        we0 = we_total;
        re0 = re_total;
        run_instr("p2.lw", 5, 32'h8, 16'h114);
        chk("p2.lw_re_cycles", re_total - re0, 1);
        chk("p2.lw_we_cycles", we_total - we0, 0);
        run_instr("p2.sw_r4", 4, 32'hC, 16'h118);
        chk("p2.sw_r4_data", wr_data, 32'hDEADBEEF);
        run_instr("p2.sub", 4, 32'h8, 16'h11C);
        run_instr("p2.and", 4, 32'h5, 16'h120);
        run_instr("p2.or", 4, 32'hFFFFFFFD, 16'h124);
        run_instr("p2.slt_t", 4, 32'h1, 16'h128);
        run_instr("p2.slt_f", 4, 32'h0, 16'h12C);
        run_instr("p2.sll", 4, 32'h50, 16'h130);
        run_instr("p2.srl", 4, 32'hF, 16'h134);
        run_instr("p2.add_r0", 4, 32'hA, 16'h138);
        run_instr("p2.read_r0", 4, 32'h0, 16'h13C);
        run_instr("p2.sw_r5", 4, 32'h4, 16'h140);
        chk("p2.sw_r5_data", wr_data, 32'h0);
        run_instr("p2.beq_nt", 3, 32'h4, 16'h144);
        run_instr("p2.j", 3, 32'h4, 16'h010);
        for (int i = 0; i < 3; i++) run_instr("p2.beq_loop", 3, 32'h4, 16'h010);

        // reset in the middle of a stalled store
        clear_imem();
        imem[64] = i_ins(8, 0, 1, 7);
        imem[65] = i_ins(32'h2B, 0, 1, 0);
        wait_cfg = 20;
        do_reset();
        run_instr("p3.addi", 4, 32'h7, 16'h104);
        n = 0;
        while (!dmem_we && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("p3.we_seen", dmem_we, 1);
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("p3.rst_pc", {16'h0, imem_addr}, 32'h100);
        chk("p3.rst_strobes", {dmem_re, dmem_we}, 0);
        chk("p3.rst_retired", retired, 0);
        reset = 1'b0;
        exp_ret = 0;
        wait_cfg = 0;
        run_instr("p3.rerun", 4, 32'h7, 16'h104);

        // illegal opcode after one good instruction
        clear_imem();
        imem[64] = i_ins(8, 0, 1, 1);
        imem[65] = 32'hF8000000;
        do_reset();
        run_instr("p4.addi", 4, 32'h1, 16'h104);
        wait_halt("p4", 2);
        chk("p4.err", err, 1);
        tick(3);
        chk("p4.retired", retired, 1);
        chk("p4.pc", {16'h0, imem_addr}, 32'h108);

        // illegal R-type funct
        clear_imem();
        imem[64] = r_ins(1, 1, 2, 0, 32'h3F);
        do_reset();
        wait_halt("p5", 2);
        chk("p5.err", err, 1);
        chk("p5.retired", retired, 0);

        chk("excl_strobes", both_seen, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
